// File: rtl/mem_ctrl_pkg.sv
// Shared types, constants and address helpers for the serial-memory access controller.
package mem_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int NUM_PORTS = 2;

    function automatic int calc_phase_bits(input int serial_bits);
        int bits;
        bits = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < serial_bits) bits = i + 1;
        end
        return bits;
    endfunction

    // Flat address = {row, slot}; callers size-cast the result to their field width.
    function automatic logic [31:0] addr_row(input logic [31:0] flat, input int phase_bits);
        return flat >> phase_bits;
    endfunction

    function automatic logic [31:0] addr_slot(input logic [31:0] flat, input int phase_bits);
        return flat & ((32'd1 << phase_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin pick: a lone requester wins, a tie goes away from last_grant.
module rr_arbiter_2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant,
    output logic       any_valid
);

    always_comb begin
        any_valid = |valid;
        grant     = 1'b0;
        case (valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Access sequencer for a recirculating shift-register memory: arbitrates two ports,
// parks each request until its slot passes the memory output, and returns the old word.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no operation held; arbitrate and accept one request
//   BUSY  | operation held; execute in the first later cycle phase==slot
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter  int ADDR_BITS   = 4,
    parameter  int DATA_BITS   = 8,
    parameter  int SERIAL_BITS = 4,
    localparam int PHASE_BITS  = calc_phase_bits(SERIAL_BITS),
    localparam int FLAT_BITS   = ADDR_BITS + PHASE_BITS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORTS-1:0]           req_valid,
    output logic [NUM_PORTS-1:0]           req_ready,
    input  logic [NUM_PORTS-1:0]           req_we,
    input  logic [NUM_PORTS*FLAT_BITS-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_BITS-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]           resp_valid,
    output logic [DATA_BITS-1:0]           resp_rdata,
    output logic                           mem_we,
    output logic [ADDR_BITS-1:0]           mem_addr,
    output logic [DATA_BITS-1:0]           mem_wdata,
    input  logic [DATA_BITS-1:0]           mem_rdata,
    output logic [PHASE_BITS-1:0]          phase
);

    state_t                state;
    logic                  last_grant;
    logic                  grant;
    logic                  any_valid;
    logic                  accept;
    logic                  exec;

    logic [FLAT_BITS-1:0]  sel_addr;
    logic [DATA_BITS-1:0]  sel_wdata;
    logic                  sel_we;

    logic                  op_we;
    logic                  op_owner;
    logic [ADDR_BITS-1:0]  op_row;
    logic [PHASE_BITS-1:0] op_slot;
    logic [DATA_BITS-1:0]  op_wdata;

    rr_arbiter_2 u_arb (
        .valid      (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .any_valid  (any_valid)
    );

    assign sel_addr  = grant ? req_addr[FLAT_BITS +: FLAT_BITS] : req_addr[0 +: FLAT_BITS];
    assign sel_wdata = grant ? req_wdata[DATA_BITS +: DATA_BITS] : req_wdata[0 +: DATA_BITS];
    assign sel_we    = req_we[grant];

    // Ready is gated by reset so nothing looks accepted while the block is held.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && !reset && any_valid) req_ready[grant] = 1'b1;
    end

    assign accept = |req_ready;
    assign exec   = (state == BUSY) && (phase == op_slot);

    // The memory bus must be live in the very cycle the slot is at the output,
    // so it is decoded from the held operation rather than registered.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (exec) begin
            mem_we    = op_we;
            mem_addr  = op_row;
            mem_wdata = op_we ? op_wdata : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase      <= '0;
            state      <= IDLE;
            last_grant <= 1'b1;
            op_we      <= 1'b0;
            op_owner   <= 1'b0;
            op_row     <= '0;
            op_slot    <= '0;
            op_wdata   <= '0;
            resp_valid <= '0;
            resp_rdata <= '0;
        end else begin
            phase      <= phase + 1'b1;
            resp_valid <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_we      <= sel_we;
                        op_owner   <= grant;
                        op_row     <= ADDR_BITS'(addr_row(32'(sel_addr), PHASE_BITS));
                        op_slot    <= PHASE_BITS'(addr_slot(32'(sel_addr), PHASE_BITS));
                        op_wdata   <= sel_wdata;
                        last_grant <= grant;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (exec) begin
                        resp_valid[op_owner] <= 1'b1;
                        resp_rdata           <= mem_rdata;
                        state                <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
